// File: rtl/sdram_defs.sv
// sdram_defs: command encodings, init states, error codes and mode-register fields shared by both ends of the SDRAM bus
package sdram_defs;
    // {ras_n, cas_n, we_n} while cs_n=0 and CKE=1; 3'b110 is unused and decodes as nothing
    typedef enum logic [2:0] {
        CMD_MRS  = 3'b000,
        CMD_REF  = 3'b001,
        CMD_PRE  = 3'b010,
        CMD_ACT  = 3'b011,
        CMD_WRIT = 3'b100,
        CMD_READ = 3'b101,
        CMD_NOP  = 3'b111
    } cmd_e;
    typedef enum logic [2:0] {WAIT_PALL, WAIT_REF1, WAIT_REF2, WAIT_MRS, READY} init_e;
    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_NOT_READY  = 3'd1;
    localparam logic [2:0] ERR_MODE       = 3'd2;
    localparam logic [2:0] ERR_ACT_ACTIVE = 3'd3;
    localparam logic [2:0] ERR_BANK_IDLE  = 3'd4;
    localparam logic [2:0] ERR_TRCD       = 3'd5;
    localparam logic [2:0] ERR_REF_ACTIVE = 3'd6;
    localparam logic [2:0] ERR_MRS_ACTIVE = 3'd7;
    localparam int MR_CL_LSB = 4;
    localparam int MR_CL_MSB = 6;
    localparam int MR_BL_MSB = 2;
    localparam int AP_BIT    = 10;
    localparam int MAX_CL    = 3;
    function automatic logic mode_legal(input logic [2:0] cl, input logic [2:0] bl);
        return (cl == 3'd2 || cl == 3'd3) && bl == 3'd0;
    endfunction
endpackage

// File: rtl/sdram_bank_tracker.sv
// sdram_bank_tracker: per-bank open-row state, tRCD countdown and bank-level protocol error flags
// Ports: i_sel selects this bank; i_act/i_rw/i_pre are decoded commands (act/rw already gated by init READY);
//        i_pre_all and i_ap are addr[10]; o_active/o_row expose state; o_err_* flag an illegal command to this bank.
module sdram_bank_tracker #(
    parameter int ROW_WIDTH = 13,
    parameter int TRCD      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sel,
    input  logic                 i_act,
    input  logic                 i_rw,
    input  logic                 i_pre,
    input  logic                 i_pre_all,
    input  logic                 i_ap,
    input  logic [ROW_WIDTH-1:0] i_row,
    output logic                 o_active,
    output logic [ROW_WIDTH-1:0] o_row,
    output logic                 o_err_act,
    output logic                 o_err_idle,
    output logic                 o_err_trcd
);
    localparam int CW = $clog2(TRCD + 1);
    logic                 r_active;
    logic [ROW_WIDTH-1:0] r_row;
    logic [CW-1:0]        r_trcd;
    logic                 w_rw_ok;
    assign o_active   = r_active;
    assign o_row      = r_row;
    assign o_err_act  = i_sel && i_act && r_active;
    assign o_err_idle = i_sel && i_rw && !r_active;
    assign o_err_trcd = i_sel && i_rw && r_active && r_trcd != '0;
    assign w_rw_ok    = i_sel && i_rw && r_active && r_trcd == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_row    <= '0;
            r_trcd   <= '0;
        end else if (i_sel && i_act && !r_active) begin
            r_active <= 1'b1;
            r_row    <= i_row;
            r_trcd   <= CW'(TRCD - 1);
        end else begin
            if (r_trcd != '0) r_trcd <= r_trcd - 1'b1;
            // auto-precharge only closes the bank when the access itself was legal
            if ((i_pre && (i_sel || i_pre_all)) || (w_rw_ok && i_ap)) r_active <= 1'b0;
        end
    end
endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: device-side SDRAM model decoding the command bus, serving single-beat reads/writes and checking protocol order
// Ports: clk/rst_n (async active-low); i_addr/i_bank_addr/i_dq_in/i_data_mask and the CKE/CS/RAS/CAS/WE strobes from
//        the controller; o_dq_out/o_dq_oe registered read beat; o_init_done, sticky o_error/o_error_code, o_refresh_count.
module sdram_responder import sdram_defs::*; #(
    parameter int ROW_WIDTH      = 13,
    parameter int COL_WIDTH      = 10,
    parameter int BANK_WIDTH     = 2,
    parameter int SDRADDR_WIDTH  = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int TRCD           = 2,
    parameter int DEFAULT_CL     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SDRADDR_WIDTH-1:0] i_addr,
    input  logic [BANK_WIDTH-1:0]    i_bank_addr,
    input  logic [7:0]               i_dq_in,
    output logic [7:0]               o_dq_out,
    output logic                     o_dq_oe,
    input  logic                     i_clock_enable,
    input  logic                     i_cs_n,
    input  logic                     i_ras_n,
    input  logic                     i_cas_n,
    input  logic                     i_we_n,
    input  logic                     i_data_mask,
    output logic                     o_init_done,
    output logic                     o_error,
    output logic [2:0]               o_error_code,
    output logic [15:0]              o_refresh_count
);
    localparam int NB = 1 << BANK_WIDTH;
    logic [2:0]                             w_cmd;
    logic                                   w_act, w_is_rd, w_is_wr, w_rw, w_pre, w_ref, w_mrs;
    logic                                   w_ready, w_mode_ok, w_any_active, w_mrs_ok, w_rw_ok, w_rd_go, w_wr_go;
    logic [NB-1:0]                          w_active, w_err_act, w_err_idle, w_err_trcd;
    logic [NB-1:0][ROW_WIDTH-1:0]           w_rows;
    logic [MEM_ADDR_WIDTH-1:0]              w_idx;
    logic [2:0]                             w_code;
    logic [MAX_CL-1:0]                      w_ins;
    logic [MAX_CL-1:0][MEM_ADDR_WIDTH-1:0]  w_pi_n;
    init_e                                  r_state, w_state_n;
    logic [2:0]                             r_cl;
    logic                                   r_err;
    logic [2:0]                             r_err_code;
    logic [15:0]                            r_ref_cnt;
    logic [MAX_CL-1:0]                      r_pv;
    logic [MAX_CL-1:0][MEM_ADDR_WIDTH-1:0]  r_pi;
    logic [7:0]                             r_dq_out;
    logic                                   r_dq_oe;
    logic [7:0]                             r_mem [1 << MEM_ADDR_WIDTH];
    assign w_cmd        = (i_clock_enable && !i_cs_n) ? {i_ras_n, i_cas_n, i_we_n} : CMD_NOP;
    assign w_act        = w_cmd == CMD_ACT;
    assign w_is_rd      = w_cmd == CMD_READ;
    assign w_is_wr      = w_cmd == CMD_WRIT;
    assign w_rw         = w_is_rd || w_is_wr;
    assign w_pre        = w_cmd == CMD_PRE;
    assign w_ref        = w_cmd == CMD_REF;
    assign w_mrs        = w_cmd == CMD_MRS;
    assign w_ready      = r_state == READY;
    assign w_any_active = |w_active;
    assign w_mode_ok    = mode_legal(i_addr[MR_CL_MSB:MR_CL_LSB], i_addr[MR_BL_MSB:0]);
    assign w_mrs_ok     = w_mrs && !w_any_active && w_mode_ok && (r_state == WAIT_MRS || w_ready);
    assign w_rw_ok      = w_rw && w_ready && !(|w_err_idle) && !(|w_err_trcd);
    assign w_rd_go      = w_rw_ok && w_is_rd;
    assign w_wr_go      = w_rw_ok && w_is_wr && !i_data_mask;
    assign w_idx        = MEM_ADDR_WIDTH'({i_bank_addr, w_rows[i_bank_addr], i_addr[COL_WIDTH-1:0]});
    assign w_code = ((w_act || w_rw) && !w_ready) ? ERR_NOT_READY :
                    (|w_err_act)                  ? ERR_ACT_ACTIVE :
                    (|w_err_idle)                 ? ERR_BANK_IDLE :
                    (|w_err_trcd)                 ? ERR_TRCD :
                    (w_ref && w_any_active)       ? ERR_REF_ACTIVE :
                    (w_mrs && w_any_active)       ? ERR_MRS_ACTIVE :
                    (w_mrs && !w_mode_ok)         ? ERR_MODE : ERR_NONE;
    // a READ enters the pipe at the stage that leaves exactly CL edges until the output register
    assign w_ins = w_rd_go ? MAX_CL'(1) << (MAX_CL - int'(r_cl)) : '0;
    always_comb begin
        w_pi_n = {r_pi[MAX_CL-2:0], MEM_ADDR_WIDTH'(0)};
        for (int j = 0; j < MAX_CL; j++) if (w_ins[j]) w_pi_n[j] = w_idx;
    end
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            WAIT_PALL: if (w_pre && i_addr[AP_BIT]) w_state_n = WAIT_REF1;
            WAIT_REF1: if (w_ref) w_state_n = WAIT_REF2;
            WAIT_REF2: if (w_ref) w_state_n = WAIT_MRS;
            WAIT_MRS:  if (w_mrs_ok) w_state_n = READY;
            default:   w_state_n = READY;
        endcase
    end
    for (genvar b = 0; b < NB; b++) begin : g_bank
        sdram_bank_tracker #(.ROW_WIDTH(ROW_WIDTH), .TRCD(TRCD)) u_trk (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_sel     (i_bank_addr == BANK_WIDTH'(b)),
            .i_act     (w_act && w_ready),
            .i_rw      (w_rw && w_ready),
            .i_pre     (w_pre),
            .i_pre_all (i_addr[AP_BIT]),
            .i_ap      (i_addr[AP_BIT]),
            .i_row     (i_addr[ROW_WIDTH-1:0]),
            .o_active  (w_active[b]),
            .o_row     (w_rows[b]),
            .o_err_act (w_err_act[b]),
            .o_err_idle(w_err_idle[b]),
            .o_err_trcd(w_err_trcd[b])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WAIT_PALL;
            r_cl       <= 3'(DEFAULT_CL);
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_ref_cnt  <= '0;
            r_pv       <= '0;
            r_pi       <= '0;
            r_dq_out   <= '0;
            r_dq_oe    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_mrs_ok) r_cl <= i_addr[MR_CL_MSB:MR_CL_LSB];
            if (!r_err && w_code != ERR_NONE) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
            end
            if (w_ref) r_ref_cnt <= r_ref_cnt + 1'b1;
            r_pv    <= {r_pv[MAX_CL-2:0], 1'b0} | w_ins;
            r_pi    <= w_pi_n;
            r_dq_oe <= r_pv[MAX_CL-1];
            if (r_pv[MAX_CL-1]) r_dq_out <= r_mem[r_pi[MAX_CL-1]];
        end
    end
    always_ff @(posedge clk) if (w_wr_go) r_mem[w_idx] <= i_dq_in;
    assign o_dq_out        = r_dq_out;
    assign o_dq_oe         = r_dq_oe;
    assign o_init_done     = w_ready;
    assign o_error         = r_err;
    assign o_error_code    = r_err_code;
    assign o_refresh_count = r_ref_cnt;
endmodule
